// File: rtl/imsic_pkg.sv
// imsic_pkg
// Shared constants and types for the IMSIC MSI delivery path.
//   SETEIPNUM_LE_OFF    : offset of seteipnum_le inside an interrupt-file page
//   IMSIC_BASE_DEFAULT  : address of seteipnum_le in interrupt file 0
//   FILE_STRIDE_DEFAULT : byte distance between consecutive interrupt files
//   msi_arb_state_e     : state encoding of the MSI arbiter sequencer
package imsic_pkg;

  localparam logic [63:0] SETEIPNUM_LE_OFF    = 64'h0000_0000;
  localparam logic [63:0] IMSIC_PAGE_BASE     = 64'h2400_0000;
  localparam logic [63:0] IMSIC_BASE_DEFAULT  = IMSIC_PAGE_BASE + SETEIPNUM_LE_OFF;
  localparam logic [63:0] FILE_STRIDE_DEFAULT = 64'h0000_1000;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_START     = 2'd1,
    ARB_WAIT_ACK  = 2'd2,
    ARB_WAIT_DONE = 2'd3
  } msi_arb_state_e;

endpackage

// File: rtl/imsic_msi_arbiter_if.sv
// imsic_msi_arbiter_if
// Connection between the MSI arbiter and the AXI-lite write master.
//   start : one-cycle pulse asking the master to issue a write
//   addr  : write address, held for the whole transaction
//   data  : write data, held for the whole transaction
//   busy  : master is executing a transaction
// Modports: master = arbiter side (drives start/addr/data),
//           slave  = write-master side (drives busy).
interface imsic_msi_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);

  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              busy;

  modport master (output start, output addr, output data, input busy);
  modport slave  (input start, input addr, input data, output busy);

endinterface

// File: rtl/imsic_msi_arbiter_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin pick: the first set bit of valid_i at or
// after ptr_i, searching upward and wrapping modulo N.
//   valid_i : request vector
//   ptr_i   : highest-priority index for this decision
//   grant_o : one-hot grant (all zero when nothing is valid)
//   idx_o   : index of the granted requester
//   any_o   : at least one requester is valid
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  // Walk the requesters starting at the pointer; the first valid one wins
  // and later candidates are ignored once any_o is set.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (!any_o && valid_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imsic_msi_arbiter.sv
// imsic_msi_arbiter
// Shares one AXI-lite write master between NR_REQ MSI sources. Each accepted
// request becomes a single seteipnum_le write; out-of-range requests are
// dropped and reported. At most one MSI is in flight at a time.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_req_valid   : per-requester MSI pending
//   o_req_ready   : one-hot accept, only in IDLE
//   i_req_file    : per-requester target interrupt file
//   i_req_eiid    : per-requester EIID
//   mst           : write-master handshake (start/addr/data out, busy in)
//   o_drop        : one-cycle pulse, accepted request was invalid
//   o_drop_id     : requester index of the dropped request
//   o_busy        : sequencer is not idle
module imsic_msi_arbiter
  import imsic_pkg::*;
#(
  parameter int          NR_REQ         = 4,
  parameter int          NR_SRC         = 30,
  parameter int          NR_INTP_FILES  = 2,
  parameter int          AXI_ADDR_WIDTH = 64,
  parameter int          AXI_DATA_WIDTH = 64,
  parameter logic [63:0] IMSIC_BASE     = IMSIC_BASE_DEFAULT,
  parameter logic [63:0] FILE_STRIDE    = FILE_STRIDE_DEFAULT,
  parameter int          FILE_LEN       = (NR_INTP_FILES > 1) ? $clog2(NR_INTP_FILES) : 1,
  parameter int          REQ_LEN        = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NR_REQ-1:0]                i_req_valid,
  output logic [NR_REQ-1:0]                o_req_ready,
  input  logic [NR_REQ-1:0][FILE_LEN-1:0]  i_req_file,
  input  logic [NR_REQ-1:0][31:0]          i_req_eiid,
  imsic_msi_arbiter_if.master              mst,
  output logic                             o_drop,
  output logic [REQ_LEN-1:0]               o_drop_id,
  output logic                             o_busy
);

  msi_arb_state_e            state_q, state_d;
  logic [REQ_LEN-1:0]        ptr_q, ptr_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic                      drop_q, drop_d;
  logic [REQ_LEN-1:0]        drop_id_q, drop_id_d;

  logic [NR_REQ-1:0]   grant;
  logic [REQ_LEN-1:0]  win;
  logic                anyValid;
  logic [FILE_LEN-1:0] winFile;
  logic [31:0]         winEiid;
  logic                winOk;

  rr_arbiter #(
    .N     (NR_REQ),
    .IDX_W (REQ_LEN)
  ) u_rr (
    .valid_i (i_req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win),
    .any_o   (anyValid)
  );

  // The winner's file/EIID are checked before anything is committed, so an
  // invalid request never reaches the master. EIID 0 is reserved.
  assign winFile = i_req_file[win];
  assign winEiid = i_req_eiid[win];
  assign winOk   = (32'(winFile) < 32'(NR_INTP_FILES)) &&
                   (winEiid != 32'd0) && (winEiid < 32'(NR_SRC));

  // Sequencer registers; reset abandons any in-flight MSI.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      drop_q    <= 1'b0;
      drop_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      drop_q    <= drop_d;
      drop_id_q <= drop_id_d;
    end
  end

  // Next-state and handshake logic. Address/data are captured at accept time
  // and held until WAIT_DONE exits. START always waits for the master to be
  // idle, which also protects against a transaction left over from before a
  // reset. Leaving WAIT_DONE goes through IDLE, so no accept happens in the
  // cycle busy is seen falling.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    drop_d      = 1'b0;
    drop_id_d   = drop_id_q;
    o_req_ready = '0;
    mst.start   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (anyValid) begin
          o_req_ready = grant;
          ptr_d = (win == REQ_LEN'(NR_REQ - 1)) ? '0 : win + 1'b1;
          if (winOk) begin
            addr_d  = IMSIC_BASE[AXI_ADDR_WIDTH-1:0] +
                      AXI_ADDR_WIDTH'(winFile) * FILE_STRIDE[AXI_ADDR_WIDTH-1:0];
            data_d  = AXI_DATA_WIDTH'(winEiid);
            state_d = ARB_START;
          end else begin
            drop_d    = 1'b1;
            drop_id_d = win;
          end
        end
      end
      ARB_START: begin
        if (!mst.busy) begin
          mst.start = 1'b1;
          state_d   = ARB_WAIT_ACK;
        end
      end
      ARB_WAIT_ACK: begin
        if (mst.busy) state_d = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE: begin
        if (!mst.busy) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign mst.addr  = addr_q;
  assign mst.data  = data_q;
  assign o_drop    = drop_q;
  assign o_drop_id = drop_id_q;
  assign o_busy    = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_imsic_msi_arbiter.sv
// tb_imsic_msi_arbiter
// Directed bench for imsic_msi_arbiter. Stimulus pushes expected accepts and
// writes into queues; a negedge monitor pops and compares whenever the DUT
// shows a ready, start or drop. A small behavioural write master answers
// start pulses with a busy window of masterLen cycles.
module tb_imsic_msi_arbiter;

  typedef struct {
    logic [1:0] idx;
    bit         ok;
  } reqExp_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wrExp_t;

  localparam logic [63:0] BASE   = 64'h2400_0000;
  localparam logic [63:0] FILE1A = 64'h2400_1000;

  logic             clk;
  logic             rst;
  logic [3:0]       reqValid;
  logic [3:0]       reqReady;
  logic [3:0][1:0]  reqFile;
  logic [3:0][31:0] reqEiid;
  logic             drop;
  logic [1:0]       dropId;
  logic             busyO;
  logic             mBusy;
  logic             extBusy;
  int               masterLen;

  int vectors;
  int miscompares;
  int acceptCnt;
  bit pendingDrop;
  logic [1:0] pendingId;

  reqExp_t expReady[$];
  wrExp_t  expStart[$];

  imsic_msi_arbiter_if #(.ADDR_W(64), .DATA_W(64)) mstIf ();

  assign mstIf.busy = mBusy | extBusy;

  // FILE_LEN widened so that an out-of-range file index can be presented.
  imsic_msi_arbiter #(.FILE_LEN(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_req_file  (reqFile),
    .i_req_eiid  (reqEiid),
    .mst         (mstIf),
    .o_drop      (drop),
    .o_drop_id   (dropId),
    .o_busy      (busyO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s", name);
  endtask

  task automatic syncIn();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic waitAccept(input logic [1:0] idx);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (reqReady[idx]) got = 1'b1;
    end
    if (!got) failNow($sformatf("accept timeout req%0d", idx));
    @(posedge clk);
    #1 reqValid[idx] = 1'b0;
  endtask

  task automatic applyStimulus(input logic [1:0] idx, input logic [1:0] file,
                               input logic [31:0] eiid, input bit ok,
                               input logic [63:0] expAddr);
    reqFile[idx]  = file;
    reqEiid[idx]  = eiid;
    reqValid[idx] = 1'b1;
    expReady.push_back('{idx: idx, ok: ok});
    if (ok) expStart.push_back('{addr: expAddr, data: {32'h0, eiid}});
    waitAccept(idx);
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 300 && !idle; c++) begin
      @(negedge clk);
      if (!busyO && !mstIf.busy && reqValid == 4'b0) idle = 1'b1;
    end
    if (!idle) failNow("idle timeout");
    syncIn();
  endtask

  // Behavioural write master: a start pulse seen at negedge is answered with
  // busy high from just after the next edge for masterLen cycles.
  initial begin
    mBusy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && mstIf.start) begin
        @(posedge clk);
        #1 mBusy = 1'b1;
        repeat (masterLen) @(posedge clk);
        #1 mBusy = 1'b0;
      end
    end
  end

  // Monitor: drop pulse must follow an invalid accept by exactly one cycle;
  // every ready and every start pops the matching expectation.
  initial begin
    reqExp_t r;
    wrExp_t  w;
    pendingDrop = 1'b0;
    pendingId   = '0;
    acceptCnt   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pendingDrop = 1'b0;
      end else begin
        if (pendingDrop || drop) begin
          checkOutput("drop pulse", 64'(drop), 64'(pendingDrop));
          if (pendingDrop) checkOutput("drop id", 64'(dropId), 64'(pendingId));
          pendingDrop = 1'b0;
        end
        if (reqReady != 4'b0) begin
          acceptCnt++;
          checkOutput("ready onehot", 64'($countones(reqReady)), 64'd1);
          if (expReady.size() == 0) begin
            failNow("unexpected accept");
          end else begin
            r = expReady.pop_front();
            checkOutput("ready grant", 64'(reqReady), 64'(4'b0001 << r.idx));
            if (!r.ok) begin
              pendingDrop = 1'b1;
              pendingId   = r.idx;
            end
          end
        end
        if (mstIf.start) begin
          if (expStart.size() == 0) begin
            failNow("unexpected start");
          end else begin
            w = expStart.pop_front();
            checkOutput("write addr", mstIf.addr, w.addr);
            checkOutput("write data", mstIf.data, w.data);
          end
        end
      end
    end
  end

  initial begin
    int target;
    vectors     = 0;
    miscompares = 0;
    masterLen   = 2;
    extBusy     = 1'b0;
    rst         = 1'b1;
    reqValid    = '0;
    reqFile     = '0;
    reqEiid     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    checkOutput("reset busy",   64'(busyO), 64'd0);
    checkOutput("reset start",  64'(mstIf.start), 64'd0);
    checkOutput("reset drop",   64'(drop), 64'd0);
    checkOutput("reset dropid", 64'(dropId), 64'd0);
    checkOutput("reset addr",   mstIf.addr, 64'd0);
    checkOutput("reset data",   mstIf.data, 64'd0);
    checkOutput("reset ready",  64'(reqReady), 64'd0);
    syncIn();

    // Single request: req 2, file 1, EIID 5
    $display("[TB] single request");
    applyStimulus(2'd2, 2'd1, 32'd5, 1'b1, FILE1A);
    @(negedge clk);
    checkOutput("start latency", 64'(mstIf.start), 64'd1);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge clk);
        if (mstIf.busy) seen = 1'b1;
      end
      if (!seen) failNow("master busy rise timeout");
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge clk);
        if (!mstIf.busy) seen = 1'b1;
      end
      if (!seen) failNow("master busy fall timeout");
      checkOutput("busy held at fall", 64'(busyO), 64'd1);
      @(negedge clk);
      checkOutput("busy after fall", 64'(busyO), 64'd0);
    end
    waitIdle();

    // All four valid: served 0,1,2,3,0
    $display("[TB] round robin");
    doReset();
    for (int i = 0; i < 4; i++) begin
      reqFile[i] = 2'd0;
      reqEiid[i] = 32'(i + 1);
    end
    for (int k = 0; k < 5; k++) begin
      expReady.push_back('{idx: 2'(k % 4), ok: 1'b1});
      expStart.push_back('{addr: BASE, data: 64'((k % 4) + 1)});
    end
    target   = acceptCnt + 5;
    reqValid = 4'b1111;
    for (int c = 0; c < 400 && acceptCnt < target; c++) @(posedge clk);
    if (acceptCnt < target) failNow("round robin accept timeout");
    #1 reqValid = 4'b0000;
    waitIdle();

    // Invalid requests are dropped back to back, then a valid one issues
    $display("[TB] invalid requests");
    doReset();
    applyStimulus(2'd1, 2'd0, 32'd0,  1'b0, 64'd0);
    applyStimulus(2'd2, 2'd1, 32'd30, 1'b0, 64'd0);
    applyStimulus(2'd3, 2'd2, 32'd5,  1'b0, 64'd0);
    applyStimulus(2'd0, 2'd1, 32'd7,  1'b1, FILE1A);
    waitIdle();

    // Master busy at request time: START holds, one start after busy falls
    $display("[TB] busy master");
    doReset();
    extBusy = 1'b1;
    applyStimulus(2'd1, 2'd0, 32'd9, 1'b1, BASE);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("start held low", 64'(mstIf.start), 64'd0);
      checkOutput("busy in start", 64'(busyO), 64'd1);
    end
    syncIn();
    extBusy = 1'b0;
    @(negedge clk);
    checkOutput("start after busy", 64'(mstIf.start), 64'd1);
    waitIdle();

    // Reset in WAIT_DONE, leftover master transaction must not be overlapped
    $display("[TB] reset in wait_done");
    doReset();
    masterLen = 8;
    applyStimulus(2'd2, 2'd0, 32'd3, 1'b1, BASE);
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge clk);
        if (mstIf.busy) seen = 1'b1;
      end
      if (!seen) failNow("wait_done entry timeout");
    end
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post-reset busy",   64'(busyO), 64'd0);
    checkOutput("post-reset start",  64'(mstIf.start), 64'd0);
    checkOutput("post-reset drop",   64'(drop), 64'd0);
    checkOutput("post-reset dropid", 64'(dropId), 64'd0);
    checkOutput("post-reset addr",   mstIf.addr, 64'd0);
    checkOutput("post-reset data",   mstIf.data, 64'd0);
    syncIn();
    reqFile[1]  = 2'd1;
    reqEiid[1]  = 32'd11;
    reqFile[3]  = 2'd0;
    reqEiid[3]  = 32'd12;
    expReady.push_back('{idx: 2'd1, ok: 1'b1});
    expReady.push_back('{idx: 2'd3, ok: 1'b1});
    expStart.push_back('{addr: FILE1A, data: 64'd11});
    expStart.push_back('{addr: BASE,   data: 64'd12});
    reqValid = 4'b1010;
    waitAccept(2'd1);
    begin
      bit low;
      low = 1'b0;
      for (int c = 0; c < 30 && !low; c++) begin
        @(negedge clk);
        if (mstIf.busy) checkOutput("start during old busy", 64'(mstIf.start), 64'd0);
        else low = 1'b1;
      end
      if (!low) failNow("leftover busy timeout");
      checkOutput("start once idle", 64'(mstIf.start), 64'd1);
    end
    masterLen = 2;
    waitAccept(2'd3);
    waitIdle();

    checkOutput("ready queue drained", 64'(expReady.size()), 64'd0);
    checkOutput("start queue drained", 64'(expStart.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
